register_bank: RTL and testbench

- Architectural register file at the consumer end of the writeback bus.
- Accepts the single arbitrated write (enable/addr/data) chosen among the Mem, AluMisc and Mult units.
- Serves two operand reads to the issue stage, with a 1-cycle registered read.
- Tracks in-flight writes per register with a pending-write counter so issue can stall on RAW and WAW hazards.

---
 rtl/register_bank_pkg.sv | 20 ++
 rtl/register_bank_if.sv | 36 +++
 rtl/register_bank_pending_counter_array.sv | 77 +++++++
 rtl/register_bank.sv | 62 ++++++
 tb/tb_register_bank.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/register_bank_pkg.sv
// Shared types and constants for the architectural register bank.
// Optional write-to-read bypass: REGBANK_WB_BYPASS_EN.
package register_bank_pkg;
  localparam int REG_ADDR_W      = 5;
  localparam int NUM_REGS        = 32;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int CNT_WIDTH_DEF   = 2;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
  } reg_req_t;

  function automatic logic is_live(input reg_addr_t a);
    return a != ZERO_REG;
  endfunction
endpackage

// File: rtl/register_bank_if.sv
// Writeback and issue-side bus of the register bank.
interface register_bank_if #(parameter int DATA_WIDTH = 32);
  logic                  wb_reg_en;
  logic [4:0]            wb_reg_addr;
  logic [DATA_WIDTH-1:0] wb_reg_data;
  logic                  iss_reg_read_en;
  logic [4:0]            iss_reg_rs_addr;
  logic [4:0]            iss_reg_rt_addr;
  logic                  iss_reg_lock_en;
  logic [4:0]            iss_reg_lock_addr;
  logic [DATA_WIDTH-1:0] reg_iss_rs_data;
  logic [DATA_WIDTH-1:0] reg_iss_rt_data;
  logic                  reg_iss_valid;
  logic                  reg_iss_rs_busy;
  logic                  reg_iss_rt_busy;
  logic                  reg_iss_lock_full;
  logic                  reg_err_underflow;

  modport master (
    output wb_reg_en, wb_reg_addr, wb_reg_data,
           iss_reg_read_en, iss_reg_rs_addr, iss_reg_rt_addr,
           iss_reg_lock_en, iss_reg_lock_addr,
    input  reg_iss_rs_data, reg_iss_rt_data, reg_iss_valid,
           reg_iss_rs_busy, reg_iss_rt_busy, reg_iss_lock_full,
           reg_err_underflow
  );

  modport slave (
    input  wb_reg_en, wb_reg_addr, wb_reg_data,
           iss_reg_read_en, iss_reg_rs_addr, iss_reg_rt_addr,
           iss_reg_lock_en, iss_reg_lock_addr,
    output reg_iss_rs_data, reg_iss_rt_data, reg_iss_valid,
           reg_iss_rs_busy, reg_iss_rt_busy, reg_iss_lock_full,
           reg_err_underflow
  );
endinterface

// File: rtl/register_bank_pending_counter_array.sv
// Per-register pending-write counters with busy/full/underflow decode.
// With REGBANK_WB_BYPASS_EN a count-1 register being written back reads as not busy.
module pending_counter_cell #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 uf_hit
);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;

  // Simultaneous lock and writeback cancel, so no underflow there.
  assign uf_hit = dec & ~inc & (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset)                             cnt <= '0;
    else if (inc && !dec && cnt != MAX)    cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)     cnt <= cnt - 1'b1;
  end
endmodule

module pending_counter_array
  import register_bank_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic      clock,
  input  logic      reset,
  input  reg_req_t  wb,
  input  reg_req_t  lock,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output logic      rs_busy,
  output logic      rt_busy,
  output logic      lock_full,
  output logic      err_underflow
);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_REGS-1:0]                uf_hit;

  assign cnt[0]    = '0;
  assign uf_hit[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cell
    pending_counter_cell #(.CNT_WIDTH(CNT_WIDTH)) u_cell (
      .clock  (clock),
      .reset  (reset),
      .inc    (lock.en && lock.addr == reg_addr_t'(r)),
      .dec    (wb.en && wb.addr == reg_addr_t'(r)),
      .cnt    (cnt[r]),
      .uf_hit (uf_hit[r])
    );
  end

  function automatic logic busy_of(input reg_addr_t a);
    logic b;
    b = cnt[a] != '0;
`ifdef REGBANK_WB_BYPASS_EN
    if (cnt[a] == CNT_WIDTH'(1) && wb.en && wb.addr == a) b = 1'b0;
`endif
    return b;
  endfunction

  assign rs_busy   = busy_of(rs_addr);
  assign rt_busy   = busy_of(rt_addr);
  assign lock_full = cnt[lock.addr] == MAX;

  always_ff @(posedge clock) begin
    if (reset)        err_underflow <= 1'b0;
    else if (|uf_hit) err_underflow <= 1'b1;
  end
endmodule

// File: rtl/register_bank.sv
// Architectural register file: one writeback port, two registered operand reads.
// REGBANK_WB_BYPASS_EN forwards a same-edge writeback into the captured operands.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input logic            clock,
  input logic            reset,
  register_bank_if.slave bus
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [DATA_WIDTH-1:0]               rs_cap, rt_cap;
  reg_req_t                            wb_req, lock_req;

  assign wb_req   = '{en: bus.wb_reg_en && is_live(bus.wb_reg_addr), addr: bus.wb_reg_addr};
  assign lock_req = '{en: bus.iss_reg_lock_en && is_live(bus.iss_reg_lock_addr),
                      addr: bus.iss_reg_lock_addr};

  // regs[0] is never written, so reads of it are 0 without extra muxing.
  always_ff @(posedge clock) begin
    if (reset)          regs <= '0;
    else if (wb_req.en) regs[wb_req.addr] <= bus.wb_reg_data;
  end

  always_comb begin
    rs_cap = regs[bus.iss_reg_rs_addr];
    rt_cap = regs[bus.iss_reg_rt_addr];
`ifdef REGBANK_WB_BYPASS_EN
    if (wb_req.en && wb_req.addr == bus.iss_reg_rs_addr) rs_cap = bus.wb_reg_data;
    if (wb_req.en && wb_req.addr == bus.iss_reg_rt_addr) rt_cap = bus.wb_reg_data;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.reg_iss_rs_data <= '0;
      bus.reg_iss_rt_data <= '0;
      bus.reg_iss_valid   <= 1'b0;
    end else begin
      bus.reg_iss_valid <= bus.iss_reg_read_en;
      if (bus.iss_reg_read_en) begin
        bus.reg_iss_rs_data <= rs_cap;
        bus.reg_iss_rt_data <= rt_cap;
      end
    end
  end

  pending_counter_array #(.CNT_WIDTH(CNT_WIDTH)) u_pend (
    .clock         (clock),
    .reset         (reset),
    .wb            (wb_req),
    .lock          (lock_req),
    .rs_addr       (bus.iss_reg_rs_addr),
    .rt_addr       (bus.iss_reg_rt_addr),
    .rs_busy       (bus.reg_iss_rs_busy),
    .rt_busy       (bus.reg_iss_rt_busy),
    .lock_full     (bus.reg_iss_lock_full),
    .err_underflow (bus.reg_err_underflow)
  );
endmodule

// File: tb/tb_register_bank.sv
// Randomized bench for register_bank against an array-based reference model.
module tb_register_bank;
  localparam int MAXC = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  register_bank_if #(.DATA_WIDTH(32)) bus();
  register_bank #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_uf;
  logic [31:0] m_rs, m_rt;
  bit          m_vld;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit exp_busy(input logic [4:0] a);
    bit b;
    b = m_cnt[a] != 0;
`ifdef REGBANK_WB_BYPASS_EN
    if (m_cnt[a] == 1 && bus.wb_reg_en && bus.wb_reg_addr == a) b = 0;
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
    m_uf = 0; m_rs = 0; m_rt = 0; m_vld = 0;
  endtask

  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic re, input logic [4:0] rs,
                      input logic [4:0] rt, input logic le, input logic [4:0] la);
    reset = rst;
    bus.wb_reg_en = we; bus.wb_reg_addr = wa; bus.wb_reg_data = wd;
    bus.iss_reg_read_en = re; bus.iss_reg_rs_addr = rs; bus.iss_reg_rt_addr = rt;
    bus.iss_reg_lock_en = le; bus.iss_reg_lock_addr = la;
    #1;
    chk("rs_busy", 32'(bus.reg_iss_rs_busy), 32'(exp_busy(rs)));
    chk("rt_busy", 32'(bus.reg_iss_rt_busy), 32'(exp_busy(rt)));
    chk("lock_full", 32'(bus.reg_iss_lock_full), 32'(m_cnt[la] == MAXC));
    @(posedge clock);
    if (rst) model_reset();
    else begin
      if (re) begin
        m_rs = m_regs[rs]; m_rt = m_regs[rt];
`ifdef REGBANK_WB_BYPASS_EN
        if (we && wa != 0 && wa == rs) m_rs = wd;
        if (we && wa != 0 && wa == rt) m_rt = wd;
`endif
      end
      m_vld = re;
      for (int r = 1; r < 32; r++) begin
        bit l, w;
        l = le && la == r;
        w = we && wa == r;
        if (l && !w && m_cnt[r] < MAXC) m_cnt[r]++;
        if (w && !l) begin
          if (m_cnt[r] > 0) m_cnt[r]--;
          else m_uf = 1;
        end
      end
      if (we && wa != 0) m_regs[wa] = wd;
    end
    #1;
    chk("valid", 32'(bus.reg_iss_valid), 32'(m_vld));
    chk("rs_data", bus.reg_iss_rs_data, m_rs);
    chk("rt_data", bus.reg_iss_rt_data, m_rt);
    chk("underflow", 32'(bus.reg_err_underflow), 32'(m_uf));
  endtask

  task automatic idle(input logic [4:0] rs);
    step(0, 0, 0, 0, 0, rs, rs, 0, rs);
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(bus.reg_iss_valid), 0);

    step(0, 0, 0, 0, 1, 3, 0, 0, 0);
    chk("tp1_valid", 32'(bus.reg_iss_valid), 1);
    chk("tp1_rs", bus.reg_iss_rs_data, 0);

    step(0, 0, 0, 0, 0, 5, 5, 1, 5);
    idle(5);
    chk("tp2_busy_gap", 32'(bus.reg_iss_rs_busy), 1);
    idle(5);
    step(0, 1, 5, 32'hDEADBEEF, 0, 5, 5, 0, 5);
    step(0, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("tp2_busy_after", 32'(bus.reg_iss_rs_busy), 0);
    chk("tp2_data", bus.reg_iss_rs_data, 32'hDEADBEEF);

    repeat (3) step(0, 0, 0, 0, 0, 7, 7, 1, 7);
    chk("tp3_full", 32'(bus.reg_iss_lock_full), 1);
    step(0, 0, 0, 0, 0, 7, 7, 1, 7);
    repeat (2) step(0, 1, 7, 32'h7, 0, 7, 7, 0, 7);
    chk("tp3_busy_mid", 32'(bus.reg_iss_rs_busy), 1);
    step(0, 1, 7, 32'h7, 0, 7, 7, 0, 7);
    chk("tp3_busy_end", 32'(bus.reg_iss_rs_busy), 0);

    step(0, 0, 0, 0, 0, 9, 9, 1, 9);
    step(0, 1, 9, 32'h99, 0, 9, 9, 1, 9);
    chk("tp4_busy", 32'(bus.reg_iss_rs_busy), 1);
    chk("tp4_no_uf", 32'(bus.reg_err_underflow), 0);
    step(0, 1, 9, 32'h9A, 0, 9, 9, 0, 9);

    step(0, 1, 12, 32'h55, 0, 12, 12, 0, 12);
    chk("tp5_uf", 32'(bus.reg_err_underflow), 1);
    step(0, 0, 0, 0, 1, 12, 12, 0, 12);
    chk("tp5_data", bus.reg_iss_rs_data, 32'h55);
    idle(12);
    chk("tp5_sticky", 32'(bus.reg_err_underflow), 1);

    step(0, 1, 4, 32'h1234, 1, 4, 0, 0, 0);
`ifdef REGBANK_WB_BYPASS_EN
    chk("tp6_bypass", bus.reg_iss_rs_data, 32'h1234);
`else
    chk("tp6_old", bus.reg_iss_rs_data, 32'h0);
`endif
    step(0, 1, 0, 32'hFFFF, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("tp6_r0", bus.reg_iss_rs_data, 0);

    step(0, 0, 0, 0, 0, 3, 3, 1, 3);
    step(1, 1, 3, 32'h33, 1, 3, 3, 1, 3);
    chk("rst_mid_uf", 32'(bus.reg_err_underflow), 0);
    step(0, 1, 3, 32'h33, 0, 3, 3, 0, 3);
    chk("rst_mid_uf_after", 32'(bus.reg_err_underflow), 1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
